// File: rtl/lsu_mem_port_pkg.sv
// Shared codes for the load/store unit: opcodes, access sizes and FSM states.
package lsu_mem_port_pkg;

  typedef enum logic [5:0] {
    LB  = 6'h20,
    LH  = 6'h21,
    LW  = 6'h23,
    LBU = 6'h24,
    LHU = 6'h25,
    SB  = 6'h28,
    SH  = 6'h29,
    SW  = 6'h2B
  } opcode_t;

  // log2 of the access width in bytes
  typedef logic [1:0] size_t;

  typedef enum logic [1:0] {BYTE, HALF, WORD} mem_size_t;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} lsu_state_t;

  // Byte offset of the access inside its word once forced to natural alignment.
  function automatic logic [1:0] natural_offset(mem_size_t size, logic [1:0] offset);
    case (size)
      HALF:    natural_offset = {offset[1], 1'b0};
      WORD:    natural_offset = 2'b00;
      default: natural_offset = offset;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering, byte enables, load extraction/extension and legality check.
// Purely combinational, zero latency; no backpressure of its own.
// LSU_MISALIGN_TRAP_EN: misaligned half/word accesses are illegal instead of being aligned down.
module lsu_align
  import lsu_mem_port_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  input  logic [31:0] readdata,
  output logic        legal,
  output logic        is_load,
  output logic        is_store,
  output logic [31:0] word_address,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  output logic [31:0] load_data
);

  opcode_t    op;
  mem_size_t  size;
  logic       sign_ext;
  logic       known;
  logic       misaligned;
  logic [1:0] offset;
  logic [31:0] rd_shifted;

  always_comb begin
    op       = opcode_t'(opcode);
    known    = 1'b1;
    is_load  = 1'b0;
    is_store = 1'b0;
    size     = WORD;
    sign_ext = 1'b0;
    case (op)
      LB:      begin is_load = 1'b1;  size = BYTE; sign_ext = 1'b1; end
      LBU:     begin is_load = 1'b1;  size = BYTE; end
      LH:      begin is_load = 1'b1;  size = HALF; sign_ext = 1'b1; end
      LHU:     begin is_load = 1'b1;  size = HALF; end
      LW:      begin is_load = 1'b1;  size = WORD; end
      SB:      begin is_store = 1'b1; size = BYTE; end
      SH:      begin is_store = 1'b1; size = HALF; end
      SW:      begin is_store = 1'b1; size = WORD; end
      default: known = 1'b0;
    endcase
  end

  assign misaligned   = ((size == HALF) && address[0]) ||
                        ((size == WORD) && (address[1:0] != 2'b00));
  assign offset       = natural_offset(size, address[1:0]);
  assign word_address = {address[31:2], 2'b00};

`ifdef LSU_MISALIGN_TRAP_EN
  assign legal = known && !misaligned;
`else
  assign legal = known;
`endif

  always_comb begin
    byteenable = 4'b1111;
    writedata  = 32'h0;
    if (is_store) begin
      case (size)
        BYTE: begin
          byteenable = 4'b0001 << offset;
          writedata  = {4{store_data[31:24]}};
        end
        HALF: begin
          byteenable = offset[1] ? 4'b1100 : 4'b0011;
          writedata  = {2{store_data[31:16]}};
        end
        default: writedata = store_data;
      endcase
    end
  end

  assign rd_shifted = readdata >> {offset, 3'b000};

  always_comb begin
    case (size)
      BYTE:    load_data = {{24{sign_ext & rd_shifted[7]}}, rd_shifted[7:0]};
      HALF:    load_data = {{16{sign_ext & rd_shifted[15]}}, rd_shifted[15:0]};
      default: load_data = rd_shifted;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store unit driving a word-aligned Avalon-style data bus from ALU address/store data.
// Latency: done 2 cycles after handshake plus wait cycles; illegal requests finish in 1.
// Backpressure: one request outstanding, req_ready_o low until the access finishes.
module lsu_mem_port
  import lsu_mem_port_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [5:0]  opcode_i,
  input  logic [31:0] address_i,
  input  logic [31:0] store_data_i,
  output logic        done_o,
  output logic        error_o,
  output logic [31:0] load_data_o,
  output logic [31:0] mem_address_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic [3:0]  mem_byteenable_o,
  output logic [31:0] mem_writedata_o,
  input  logic        mem_waitrequest_i,
  input  logic [31:0] mem_readdata_i
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  lsu_state_t    state;
  logic [5:0]    opcode_q;
  logic [31:0]   address_q;
  logic [CW-1:0] wait_cnt;
  logic          idle;

  logic          legal;
  logic          is_load;
  logic          is_store;
  logic [31:0]   word_address;
  logic [3:0]    byteenable;
  logic [31:0]   writedata;
  logic [31:0]   load_data;

  assign idle        = (state == IDLE);
  assign req_ready_o = reset_n_i && idle;

  // In IDLE the aligner looks at the incoming request; afterwards at the captured one.
  lsu_align u_align (
    .opcode       (idle ? opcode_i  : opcode_q),
    .address      (idle ? address_i : address_q),
    .store_data   (store_data_i),
    .readdata     (mem_readdata_i),
    .legal        (legal),
    .is_load      (is_load),
    .is_store     (is_store),
    .word_address (word_address),
    .byteenable   (byteenable),
    .writedata    (writedata),
    .load_data    (load_data)
  );

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state            <= IDLE;
      opcode_q         <= '0;
      address_q        <= '0;
      wait_cnt         <= '0;
      done_o           <= 1'b0;
      error_o          <= 1'b0;
      load_data_o      <= '0;
      mem_address_o    <= '0;
      mem_read_o       <= 1'b0;
      mem_write_o      <= 1'b0;
      mem_byteenable_o <= '0;
      mem_writedata_o  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            opcode_q  <= opcode_i;
            address_q <= address_i;
            if (!legal) begin
              done_o  <= 1'b1;
              error_o <= 1'b1;
              state   <= DONE;
            end else begin
              mem_read_o       <= is_load;
              mem_write_o      <= is_store;
              mem_address_o    <= word_address;
              mem_byteenable_o <= byteenable;
              mem_writedata_o  <= writedata;
              wait_cnt         <= '0;
              state            <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (!mem_waitrequest_i) begin
            mem_read_o  <= 1'b0;
            mem_write_o <= 1'b0;
            if (mem_read_o) load_data_o <= load_data;
            done_o      <= 1'b1;
            error_o     <= 1'b0;
            state       <= DONE;
          end else if ((TIMEOUT_CYCLES != 0) && (wait_cnt == WAIT_LAST)) begin
            mem_read_o  <= 1'b0;
            mem_write_o <= 1'b0;
            done_o      <= 1'b1;
            error_o     <= 1'b1;
            state       <= DONE;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        DONE: begin
          done_o  <= 1'b0;
          error_o <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Load/store unit sitting between the execute-stage ALU and the Avalon-style data memory bus. Accepts one effective address plus left-justified store data per request, converts it into a word-aligned bus transaction with byte enables, honours `mem_waitrequest_i`, and returns right-justified, sign- or zero-extended load data. It is the memory-side counterpart of the ALU's address/store-data outputs and the sole driver of the data bus.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 256: maximum consecutive cycles of `mem_waitrequest_i` before the access is aborted with an error. 0 disables the timeout.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset_n_i`  in  1  asynchronous, active-low reset.
- `req_valid_i`  in  1  request present this cycle.
- `req_ready_o`  out  1  unit idle; a request is accepted when `req_valid_i & req_ready_o`.
- `opcode_i`  in  6  `opcode_t`: LB, LBU, LH, LHU, LW, SB, SH or SW.
- `address_i`  in  32  effective byte address.
- `store_data_i`  in  32  left-justified store value: byte in [31:24], half in [31:16].
- `done_o`  out  1  one-cycle pulse when an access completes or errors.
- `error_o`  out  1  qualified by `done_o`: misaligned, illegal opcode or timeout.
- `load_data_o`  out  32  extended load result; valid with `done_o` and held until the next `done_o`.
- `mem_address_o`  out  32  word-aligned bus address, with [1:0] = 0.
- `mem_read_o`  out  1  bus read strobe.
- `mem_write_o`  out  1  bus write strobe.
- `mem_byteenable_o`  out  4  byte lanes. Lane n is bits [8n+7:8n].
- `mem_writedata_o`  out  32  lane-aligned write data.
- `mem_waitrequest_i`  in  1  slave stall.
- `mem_readdata_i`  in  32  read data; valid in the cycle `mem_waitrequest_i` is low.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - `req_ready_o` = 1.
  - On handshake, register opcode, address and store data.
  - If the request is illegal, go to DONE with the error flag set. Otherwise go to ACCESS.
- ACCESS:
  - Assert `mem_read_o` (loads) or `mem_write_o` (stores).
  - Hold address, byte enables and write data stable while `mem_waitrequest_i` = 1.
  - When `mem_waitrequest_i` = 0:
    - Deassert the strobe on the next edge.
    - Capture the extended read data.
    - Go to DONE.
- DONE:
  - `done_o` = 1 for exactly one cycle, then return to IDLE.
- Little-endian lane mapping: address[1:0] = k selects lane k.
- Stores:
  - SB: `mem_writedata_o` = {4{byte}}, `mem_byteenable_o` = 4'b0001 << address[1:0].
  - SH: `mem_writedata_o` = {2{half}}, `mem_byteenable_o` = 4'b0011 if address[1] = 0, else 4'b1100.
  - SW: full word, `mem_byteenable_o` = 4'b1111.
- Loads:
  - Always issue with `mem_byteenable_o` = 4'b1111.
  - Extract the selected byte, half or word.
  - LB and LH sign-extend; LBU and LHU zero-extend.
- Illegal opcode: no bus cycle issued; `done_o` and `error_o` asserted; `load_data_o` unchanged.
- Timeout: a counter increments on each ACCESS cycle with `mem_waitrequest_i` = 1. Reaching `TIMEOUT_CYCLES` drops the strobe, then raises `done_o` with `error_o` set.

## Timing
- Reset values of all outputs:
  - `req_ready_o` = 0 while reset is asserted, then 1 in IDLE.
  - `done_o`, `error_o`, `mem_read_o`, `mem_write_o` = 0.
  - `load_data_o`, `mem_address_o`, `mem_writedata_o` = 0.
  - `mem_byteenable_o` = 0.
- Reset asserted mid-access: strobes drop asynchronously, FSM returns to IDLE, no `done_o` is produced.
- Latency with zero wait states:
  - Handshake at edge 0.
  - Strobe high in cycle 1.
  - `done_o` high in cycle 2.
- Latency with N wait cycles: `done_o` in cycle 2+N.
- Illegal request: `done_o` in cycle 1.
- `req_ready_o` is low in ACCESS and DONE. At most one request is outstanding.
- Bus outputs are registered and do not change while the strobe is high and `mem_waitrequest_i` = 1.
- `mem_read_o` and `mem_write_o` are never high together.

## Configuration
- `LSU_MISALIGN_TRAP_EN`
  - Defined: halfword accesses with address[0] = 1, and word accesses with address[1:0] ≠ 0, are illegal. They take the error path with no bus cycle.
  - Undefined: misaligned low address bits are silently cleared to natural alignment and the access proceeds normally.

## Structure
- Shared `codes` package holds:
  - The `lsu_state_t` enum.
  - A `mem_size_t` enum (BYTE, HALF, WORD).
  - The existing `opcode_t` and `size_t`.
- One sub-module, `lsu_align`: purely combinational. Covers lane steering, byte-enable generation, load extraction/extension and the legality check. The FSM, timeout counter and registers stay in `lsu_mem_port`.

## Test plan
- SW at 0x1000, data 0xDEADBEEF, zero wait → `mem_address_o` = 0x1000, `mem_byteenable_o` = 4'b1111, `mem_writedata_o` = 0xDEADBEEF; `done_o` in cycle 2; `error_o` = 0.
- SB at 0x1003, `store_data_i` = 0xA5000000 → `mem_byteenable_o` = 4'b1000, `mem_writedata_o` = 0xA5A5A5A5, `mem_address_o` = 0x1000.
- LB at 0x2001, readdata 0x0000F000, 3 wait cycles → strobe held 4 cycles; `load_data_o` = 0xFFFFFFF0; `done_o` in cycle 5. LBU of the same access → 0x000000F0.
- LH at 0x2002, readdata 0x80010000 → `load_data_o` = 0xFFFF8001. LHU of the same access → 0x00008001.
- LW at 0x2002 with `LSU_MISALIGN_TRAP_EN`: no strobe; `done_o` & `error_o` in cycle 1. Without the macro: read at 0x2000, `error_o` = 0.
- Waitrequest stuck high with `TIMEOUT_CYCLES` = 4 → strobe drops after 4 cycles, `done_o` & `error_o` pulse. Separately, `reset_n_i` low mid-ACCESS → `mem_read_o` = 0 immediately, no `done_o`, `req_ready_o` = 1 after release.
